// File: rtl/gray_counter_arbiter.sv
// gray_counter_arbiter
// Round-robin arbiter that shares one GrayCounter among nreq requesters.
// A grant latches the requester's op and value, then drives exactly one counter
// method enable for one cycle. The post-operation counter value is returned to
// the granted requester two cycles later.
//
// Ports:
//   CLK, nRST                  clock (rising edge), async active-low reset
//   req__ENA  [nreq]           per-requester request valid
//   req__op   [2*nreq]         per-requester opcode: 0 INC, 1 DEC, 2 LOADBIN, 3 LOADGRAY
//   req__v    [width*nreq]     per-requester load value
//   req__RDY  [nreq]           one-hot accept strobe (combinational)
//   rsp__ENA  [nreq]           one-hot response strobe
//   rsp__gray, rsp__bin [width]  counter value after the granted operation
//   cnt__*__ENA                counter method enables
//   cnt__writeBin__v, cnt__writeGray__v [width]  counter load data
//   cnt__readGray, cnt__readBin [width]          counter outputs
module gray_counter_arbiter #(
  parameter int unsigned width = 10,
  parameter int unsigned nreq  = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [nreq-1:0]         req__ENA,
  input  logic [2*nreq-1:0]       req__op,
  input  logic [width*nreq-1:0]   req__v,
  output logic [nreq-1:0]         req__RDY,
  output logic [nreq-1:0]         rsp__ENA,
  output logic [width-1:0]        rsp__gray,
  output logic [width-1:0]        rsp__bin,
  output logic                    cnt__increment__ENA,
  output logic                    cnt__decrement__ENA,
  output logic                    cnt__writeBin__ENA,
  output logic                    cnt__writeGray__ENA,
  output logic [width-1:0]        cnt__writeBin__v,
  output logic [width-1:0]        cnt__writeGray__v,
  input  logic [width-1:0]        cnt__readGray,
  input  logic [width-1:0]        cnt__readBin
);

  localparam int unsigned ID_W = (nreq > 1) ? $clog2(nreq) : 1;

  localparam logic [1:0] OP_INC   = 2'd0;
  localparam logic [1:0] OP_DEC   = 2'd1;
  localparam logic [1:0] OP_LDBIN = 2'd2;
  localparam logic [1:0] OP_LDGRY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [width-1:0]    r_v;
  logic                r_inc;
  logic                r_dec;
  logic                r_wbin;
  logic                r_wgray;
  logic [nreq-1:0]     r_rsp_ena;
  logic [width-1:0]    r_rsp_gray;
  logic [width-1:0]    r_rsp_bin;

  logic [1:0]          w_op_arr [nreq];
  logic [width-1:0]    w_v_arr  [nreq];
  logic                w_found;
  logic [ID_W-1:0]     w_gnt_id;
  logic [1:0]          w_gnt_op;
  logic [width-1:0]    w_gnt_v;
  logic                w_accept;

  // Unpack the per-requester buses so the grant index can select directly.
  always_comb begin
    for (int i = 0; i < int'(nreq); i++) begin
      w_op_arr[i] = req__op[2*i +: 2];
      w_v_arr[i]  = req__v[width*i +: width];
    end
  end

  // First requesting index at or after r_rr_ptr, searching upward modulo nreq.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int unsigned k = 0; k < nreq; k++) begin
      idx = 32'(r_rr_ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!w_found && req__ENA[ID_W'(idx)]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'(idx);
      end
    end
    w_gnt_op = w_op_arr[w_gnt_id];
    w_gnt_v  = w_v_arr[w_gnt_id];
  end

  // Accepts overlap the RESP cycle; ISSUE is the only busy state.
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && w_found;

  always_comb begin
    req__RDY = '0;
    if (w_accept) req__RDY[w_gnt_id] = 1'b1;
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = w_accept ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: method enables are decoded at accept so they are high exactly in ISSUE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_v        <= '0;
      r_inc      <= 1'b0;
      r_dec      <= 1'b0;
      r_wbin     <= 1'b0;
      r_wgray    <= 1'b0;
      r_rsp_ena  <= '0;
      r_rsp_gray <= '0;
      r_rsp_bin  <= '0;
    end else begin
      r_inc   <= w_accept && (w_gnt_op == OP_INC);
      r_dec   <= w_accept && (w_gnt_op == OP_DEC);
      r_wbin  <= w_accept && (w_gnt_op == OP_LDBIN);
      r_wgray <= w_accept && (w_gnt_op == OP_LDGRY);
      if (w_accept) begin
        r_id <= w_gnt_id;
        r_v  <= w_gnt_v;
      end
      if (r_state == ST_ISSUE) begin
        r_rr_ptr <= (r_id == ID_W'(nreq - 1)) ? '0 : r_id + ID_W'(1);
      end
      r_rsp_ena <= '0;
      if (r_state == ST_RESP) begin
        r_rsp_ena  <= nreq'(1) << r_id;
        r_rsp_gray <= cnt__readGray;
        r_rsp_bin  <= cnt__readBin;
      end
    end
  end

  assign rsp__ENA            = r_rsp_ena;
  assign rsp__gray           = r_rsp_gray;
  assign rsp__bin            = r_rsp_bin;
  assign cnt__increment__ENA = r_inc;
  assign cnt__decrement__ENA = r_dec;
  assign cnt__writeBin__ENA  = r_wbin;
  assign cnt__writeGray__ENA = r_wgray;
  assign cnt__writeBin__v    = r_v;
  assign cnt__writeGray__v   = r_v;

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Testbench for gray_counter_arbiter: behavioural GrayCounter attached to the
// counter ports, a reference model that predicts grants, counter enables and
// responses, and a monitor that pops expected responses from a scoreboard queue.
module tb_gray_counter_arbiter;

  localparam int unsigned W = 10;
  localparam int unsigned N = 4;
  localparam int unsigned MOD = 1 << W;

  localparam logic [1:0] OP_INC   = 2'd0;
  localparam logic [1:0] OP_DEC   = 2'd1;
  localparam logic [1:0] OP_LDBIN = 2'd2;
  localparam logic [1:0] OP_LDGRY = 2'd3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             nRST = 1'b0;
  logic             cnt_rst_n = 1'b0;
  logic [N-1:0]     req_ena = '0;
  logic [2*N-1:0]   req_op = '0;
  logic [W*N-1:0]   req_v = '0;
  logic [N-1:0]     req_rdy;
  logic [N-1:0]     rsp_ena;
  logic [W-1:0]     rsp_gray, rsp_bin;
  logic             cnt_inc, cnt_dec, cnt_wbin, cnt_wgray;
  logic [W-1:0]     cnt_wbin_v, cnt_wgray_v;
  logic [W-1:0]     cnt_gray, cnt_bin;

  gray_counter_arbiter #(.width(W), .nreq(N)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .req__ENA(req_ena),
    .req__op(req_op),
    .req__v(req_v),
    .req__RDY(req_rdy),
    .rsp__ENA(rsp_ena),
    .rsp__gray(rsp_gray),
    .rsp__bin(rsp_bin),
    .cnt__increment__ENA(cnt_inc),
    .cnt__decrement__ENA(cnt_dec),
    .cnt__writeBin__ENA(cnt_wbin),
    .cnt__writeGray__ENA(cnt_wgray),
    .cnt__writeBin__v(cnt_wbin_v),
    .cnt__writeGray__v(cnt_wgray_v),
    .cnt__readGray(cnt_gray),
    .cnt__readBin(cnt_bin)
  );

  // Behavioural GrayCounter (its own reset, not tied to nRST).
  logic [W-1:0] c_bin;
  always @(posedge CLK or negedge cnt_rst_n) begin
    if (!cnt_rst_n) c_bin <= '0;
    else if (cnt_wbin) c_bin <= cnt_wbin_v;
    else if (cnt_wgray) begin
      logic [W-1:0] b;
      b = '0;
      for (int i = 0; i < int'(W); i++) b = b ^ (cnt_wgray_v >> i);
      c_bin <= b;
    end
    else if (cnt_inc && !cnt_dec) c_bin <= c_bin + W'(1);
    else if (cnt_dec && !cnt_inc) c_bin <= c_bin - W'(1);
  end
  assign cnt_bin  = c_bin;
  assign cnt_gray = c_bin ^ (c_bin >> 1);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference arithmetic.
  function automatic logic [W-1:0] ref_gray(logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < int'(W) - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic logic [W-1:0] ref_g2b(logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] ref_apply(logic [W-1:0] b, logic [1:0] op, logic [W-1:0] v);
    case (op)
      OP_INC:   return W'((32'(b) + 1) % MOD);
      OP_DEC:   return W'((32'(b) + MOD - 1) % MOD);
      OP_LDBIN: return v;
      default:  return ref_g2b(v);
    endcase
  endfunction

  typedef struct {
    int           id;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    int           due;
  } exp_t;
  exp_t sbq[$];

  // Reference model state.
  int unsigned  m_ptr = 0;
  logic [W-1:0] m_bin = '0;
  bit           pend_valid = 1'b0;
  int           pend_id = 0;
  logic [1:0]   pend_op = '0;
  logic [W-1:0] pend_v = '0;
  logic [N-1:0] grant_mask = '0;
  int           acc_count = 0;
  logic [3:0]   m_exp_en;
  bit           m_was_issue;
  int           m_idx;
  exp_t         m_e;

  // Model: predicts enables during the issue cycle and the grant of this cycle.
  always @(negedge CLK) begin
    if (!nRST) begin
      pend_valid = 1'b0;
      m_ptr      = 0;
      grant_mask = '0;
      sbq.delete();
    end else begin
      m_exp_en = pend_valid ? (4'b0001 << pend_op) : 4'b0000;
      check("cnt_enables", 32'({cnt_wgray, cnt_wbin, cnt_dec, cnt_inc}), 32'(m_exp_en));
      if (cnt_inc || cnt_dec) check("inc_dec_exclusive", 32'(cnt_inc & cnt_dec), 32'(0));
      m_was_issue = pend_valid;
      if (pend_valid) begin
        check("wbin_v", 32'(cnt_wbin_v), 32'(pend_v));
        check("wgray_v", 32'(cnt_wgray_v), 32'(pend_v));
        m_bin    = ref_apply(m_bin, pend_op, pend_v);
        m_e.id   = pend_id;
        m_e.bin  = m_bin;
        m_e.gray = ref_gray(m_bin);
        m_e.due  = cyc + 2;
        sbq.push_back(m_e);
        pend_valid = 1'b0;
      end
      grant_mask = '0;
      if (!m_was_issue) begin
        for (int k = 0; k < int'(N); k++) begin
          m_idx = (int'(m_ptr) + k) % int'(N);
          if (grant_mask == '0 && req_ena[m_idx]) begin
            grant_mask[m_idx] = 1'b1;
            pend_valid = 1'b1;
            pend_id    = m_idx;
            pend_op    = req_op[2*m_idx +: 2];
            pend_v     = req_v[W*m_idx +: W];
            m_ptr      = 32'((m_idx + 1) % int'(N));
            acc_count++;
          end
        end
      end
      check("req_rdy", 32'(req_rdy), 32'(grant_mask));
    end
  end

  // Monitor: compares each response strobe against the scoreboard head.
  always @(negedge CLK) begin
    if (nRST) begin
      if (rsp_ena != '0) begin
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_ena), 32'(0));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rsp_id", 32'(rsp_ena), 32'(1) << e.id);
          check("rsp_bin", 32'(rsp_bin), 32'(e.bin));
          check("rsp_gray", 32'(rsp_gray), 32'(e.gray));
          check("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_missing", 32'(rsp_ena), 32'(1) << e.id);
      end
    end
  end

  task automatic set_req(int id, logic [1:0] op, logic [W-1:0] v);
    req_ena[id]         = 1'b1;
    req_op[2*id +: 2]   = op;
    req_v[W*id +: W]    = v;
  endtask

  task automatic issue(int id, logic [1:0] op, logic [W-1:0] v);
    bit ok;
    ok = 1'b0;
    @(posedge CLK); #1;
    set_req(id, op, v);
    for (int t = 0; t < 30; t++) begin
      @(negedge CLK); #1;
      if (grant_mask[id]) begin ok = 1'b1; break; end
    end
    check("grant_seen", 32'(ok), 32'(1));
    @(posedge CLK); #1;
    req_ena[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK); #1;
      if (sbq.size() == 0 && !pend_valid && req_ena == '0) begin ok = 1'b1; break; end
    end
    check("drain", 32'(ok), 32'(1));
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rdy"}, 32'(req_rdy), 32'(0));
    check({tag, "_rsp_ena"}, 32'(rsp_ena), 32'(0));
    check({tag, "_cnt_ena"}, 32'({cnt_wgray, cnt_wbin, cnt_dec, cnt_inc}), 32'(0));
    check({tag, "_rsp_gray"}, 32'(rsp_gray), 32'(0));
    check({tag, "_rsp_bin"}, 32'(rsp_bin), 32'(0));
    check({tag, "_wbin_v"}, 32'(cnt_wbin_v), 32'(0));
    check({tag, "_wgray_v"}, 32'(cnt_wgray_v), 32'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev;
    bit ok;
    int acc_start;

    // Reset values.
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK); #2;
    nRST = 1'b1;
    cnt_rst_n = 1'b1;

    // Single INC from 0.
    issue(0, OP_INC, '0);
    wait_idle();
    check("t1_bin", 32'(rsp_bin), 32'(1));
    check("t1_gray", 32'(rsp_gray), 32'(1));

    // LOADBIN 5 then DEC on requester 2.
    issue(2, OP_LDBIN, W'(5));
    wait_idle();
    check("t2_load_bin", 32'(rsp_bin), 32'(5));
    check("t2_load_gray", 32'(rsp_gray), 32'(7));
    issue(2, OP_DEC, '0);
    wait_idle();
    check("t2_dec_bin", 32'(rsp_bin), 32'(4));
    check("t2_dec_gray", 32'(rsp_gray), 32'(6));

    // Clear counter from requester 3 (pointer returns to 0), then all four INC.
    issue(3, OP_LDBIN, '0);
    wait_idle();
    @(posedge CLK); #1;
    for (int i = 0; i < int'(N); i++) set_req(i, OP_INC, '0);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge CLK); #1;
        if (req_rdy != '0) begin ok = 1'b1; break; end
      end
      check("t3_grant_order", 32'(req_rdy), 32'(1) << (k % int'(N)));
      if (k > 0 && ok) check("t3_spacing", 32'(cyc - prev), 32'(2));
      prev = cyc;
    end
    @(posedge CLK); #1;
    req_ena = '0;
    wait_idle();
    check("t3_bin", 32'(rsp_bin), 32'(8));
    check("t3_gray", 32'(rsp_gray), 32'(12));

    // LOADGRAY 0x200 then INC wraps to 0.
    issue(0, OP_LDGRY, W'(10'h200));
    wait_idle();
    check("t4_ldg_bin", 32'(rsp_bin), 32'(1023));
    check("t4_ldg_gray", 32'(rsp_gray), 32'(10'h200));
    issue(0, OP_INC, '0);
    wait_idle();
    check("t4_wrap_bin", 32'(rsp_bin), 32'(0));
    check("t4_wrap_gray", 32'(rsp_gray), 32'(0));

    // DEC at 0 wraps to all-ones; requester 1 leaves the pointer at 2.
    issue(1, OP_DEC, '0);
    wait_idle();
    check("t5_bin", 32'(rsp_bin), 32'(1023));
    check("t5_gray", 32'(rsp_gray), 32'(10'h200));

    // Reset in the cycle after an accept discards the op.
    @(posedge CLK); #1;
    set_req(3, OP_LDBIN, W'(10'h155));
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK); #1;
      if (grant_mask[3]) begin ok = 1'b1; break; end
    end
    check("t6_grant", 32'(ok), 32'(1));
    @(posedge CLK); #3;
    nRST = 1'b0;
    req_ena = '0;
    #1;
    check_all_zero("t6_async");
    @(negedge CLK);
    @(negedge CLK); #2;
    nRST = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge CLK); #1;
      check("t6_no_rsp", 32'(rsp_ena), 32'(0));
    end
    @(posedge CLK); #1;
    for (int i = 0; i < int'(N); i++) set_req(i, OP_INC, '0);
    @(negedge CLK); #1;
    check("t6_first_grant", 32'(req_rdy), 32'(1));
    @(posedge CLK); #1;
    req_ena = '0;
    wait_idle();
    check("t6_bin_kept", 32'(rsp_bin), 32'(0));

    // Randomised run of 10000 operations.
    acc_start = acc_count;
    ok = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(posedge CLK); #1;
      if (acc_count - acc_start >= 10000) begin ok = 1'b1; break; end
      for (int i = 0; i < int'(N); i++) begin
        if (grant_mask[i]) begin
          if ($urandom_range(1, 0) == 0) req_ena[i] = 1'b0;
          else set_req(i, 2'($urandom), W'($urandom));
        end else if (!req_ena[i] && $urandom_range(99, 0) < 60) begin
          set_req(i, 2'($urandom), W'($urandom));
        end
      end
    end
    check("rand_ops_done", 32'(ok), 32'(1));
    req_ena = '0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
